// File: rtl/multiplicador_shift_add_pkg.sv
// ============================================================================
// multiplicador_pkg -- shared types and constants for the shift-add multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package multiplicador_pkg;

  localparam int N_DEF = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/multiplicador_shift_add_if.sv
// ============================================================================
// multiplicador_shift_add_if -- start/done handshake and operand/result bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface multiplicador_shift_add_if #(
  parameter int N = multiplicador_pkg::N_DEF
);

  logic           St;
  logic [N-1:0]   Multiplicando;
  logic [N-1:0]   Multiplicador;
  logic           Idle;
  logic           Done;
  logic [2*N-1:0] Produto;

  modport master (
    output St,
    output Multiplicando,
    output Multiplicador,
    input  Idle,
    input  Done,
    input  Produto
  );

  modport slave (
    input  St,
    input  Multiplicando,
    input  Multiplicador,
    output Idle,
    output Done,
    output Produto
  );

endinterface

`default_nettype wire

// File: rtl/multiplicador_shift_add_datapath.sv
// ============================================================================
// multiplicador_datapath -- ACC/MCAND registers, (N+1)-bit adder and shift
// Rev 1.0 -- MULT_RESULT_REG_EN adds a held result register
// ============================================================================
`default_nettype none

module multiplicador_datapath
  import multiplicador_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           load_i,
  input  wire logic           step_i,
`ifdef MULT_RESULT_REG_EN
  input  wire logic           latch_i,
`endif
  input  wire logic [N-1:0]   multiplicando_i,
  input  wire logic [N-1:0]   multiplicador_i,
  output logic      [2*N-1:0] produto_o
);

  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   addend;
  logic [N:0]     sum;

  // The adder carry becomes the new MSB, so the shifted ACC never overflows.
  always_comb begin
    addend  = acc_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q[2*N-1:N]} + {1'b0, addend};
    acc_d   = acc_q;
    mcand_d = mcand_q;
    if (load_i) begin
      acc_d   = {{N{1'b0}}, multiplicador_i};
      mcand_d = multiplicando_i;
    end else if (step_i) begin
      acc_d   = {sum, acc_q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
    end
  end

`ifdef MULT_RESULT_REG_EN
  logic [2*N-1:0] res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (latch_i) begin
      res_q <= acc_d;
    end
  end

  assign produto_o = res_q;
`else
  assign produto_o = acc_q;
`endif

endmodule

`default_nettype wire

// File: rtl/multiplicador_shift_add.sv
// ============================================================================
// multiplicador_shift_add -- sequential NxN shift-add multiplier, Moore FSM
// Rev 1.0 -- optional MULT_RESULT_REG_EN keeps Produto stable during CALC
// ============================================================================
`default_nettype none

module multiplicador_shift_add
  import multiplicador_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  wire logic                  Clk,
  input  wire logic                  Rst,
  multiplicador_shift_add_if.slave   bus
);

  localparam int CW = cnt_width(N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load;
  logic          step;
  logic          last_step;

  assign last_step = (state_q == CALC) && (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.St) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  multiplicador_datapath #(
    .N (N)
  ) u_datapath (
    .clk             (Clk),
    .rst             (Rst),
    .load_i          (load),
    .step_i          (step),
`ifdef MULT_RESULT_REG_EN
    .latch_i         (last_step),
`endif
    .multiplicando_i (bus.Multiplicando),
    .multiplicador_i (bus.Multiplicador),
    .produto_o       (bus.Produto)
  );

  assign bus.Idle = (state_q == IDLE);
  assign bus.Done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_multiplicador_shift_add.sv
// ============================================================================
// tb_multiplicador_shift_add -- randomized scoreboard bench for the multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multiplicador_shift_add;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic [2*N-1:0] prod;
    int             done_cyc;
  } exp_t;

  exp_t sb_q[$];

  multiplicador_shift_add_if #(.N(N)) bus ();

  multiplicador_shift_add #(
    .N (N)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[2*N-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever Done is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Idle && bus.Done) begin
        checks++;
        failures++;
        $display("FAIL idle_done_overlap: Idle=1 Done=1 at cycle %0d", cyc);
      end
      if (bus.Done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: Done=1 with empty scoreboard at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("product", 32'(bus.Produto), 32'(e.prod));
          check("done_latency", 32'(cyc), 32'(e.done_cyc));
        end
      end
    end
  end

  // St and operands may be scrambled during CALC; the captured values must win.
  task automatic do_op(input logic [N-1:0] mcand, input logic [N-1:0] mplier, input bit disturb);
    logic [2*N-1:0] e;
    e = ref_mul(mcand, mplier);
    @(negedge clk);
    bus.St            = 1'b1;
    bus.Multiplicando = mcand;
    bus.Multiplicador = mplier;
    sb_q.push_back('{prod: e, done_cyc: cyc + 1 + N});
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.St = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
      if (disturb) begin
        bus.Multiplicando = N'($urandom);
        bus.Multiplicador = N'($urandom);
      end
      @(negedge clk);
    end
    bus.St = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_op", 32'(bus.Idle), 32'd1);
    check("product_held", 32'(bus.Produto), 32'(e));
  endtask

  task automatic back_to_back(input logic [N-1:0] mcand, input logic [N-1:0] mplier);
    logic [2*N-1:0] e;
    e = ref_mul(mcand, mplier);
    @(negedge clk);
    bus.St            = 1'b1;
    bus.Multiplicando = mcand;
    bus.Multiplicador = mplier;
    sb_q.push_back('{prod: e, done_cyc: cyc + 1 + N});
    sb_q.push_back('{prod: e, done_cyc: cyc + 1 + N + N + 2});
    repeat (6) @(negedge clk);
    check("b2b_idle_gap", 32'(bus.Idle), 32'd1);
    @(negedge clk);
    check("b2b_restarted", 32'(bus.Idle), 32'd0);
    bus.St = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_idle_end", 32'(bus.Idle), 32'd1);
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    cyc               = 0;
    rst               = 1'b1;
    bus.St            = 1'b0;
    bus.Multiplicando = '0;
    bus.Multiplicador = '0;
    repeat (2) @(negedge clk);
    check("reset_idle", 32'(bus.Idle), 32'd1);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_produto", 32'(bus.Produto), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(bus.Idle), 32'd1);

    do_op(4'b1101, 4'b1011, 1'b0);
    do_op(4'b1111, 4'b1111, 1'b0);
    do_op(4'd13, 4'd0, 1'b0);
    do_op(4'd15, 4'd1, 1'b0);
    do_op(4'b1101, 4'b1011, 1'b1);
    back_to_back(4'd9, 4'd7);

    // Abort an operation two cycles into CALC; its result must never appear.
    @(negedge clk);
    bus.St            = 1'b1;
    bus.Multiplicando = 4'd11;
    bus.Multiplicador = 4'd13;
    @(negedge clk);
    bus.St = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_idle", 32'(bus.Idle), 32'd1);
    check("midrst_done", 32'(bus.Done), 32'd0);
    check("midrst_produto", 32'(bus.Produto), 32'd0);
    repeat (6) @(negedge clk);
    do_op(4'd11, 4'd13, 1'b0);

    for (int k = 0; k < 20; k++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: %0d products never reported", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiplicador_shift_add.md
Name: multiplicador_shift_add

Overview:
- Sequential unsigned N×N shift-add multiplier with start/done handshake; N defaults to 4.
- One add-and-shift step per clock, four steps for the default width.
- Used as a small arithmetic slave: a controller pulses St, waits for Done, then reads Produto.
- Control is a Moore FSM; the datapath is a 2N-bit accumulator/shift register plus an (N+1)-bit adder.

Parameters:
- N, 4, operand width; Produto is 2N bits; step counter is clog2(N)+1 bits.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous active-high reset.
- St  in  1  start request; sampled only in IDLE.
- Multiplicando  in  N  unsigned multiplicand; captured on start.
- Multiplicador  in  N  unsigned multiplier; captured on start.
- Idle  out  1  high while FSM is in IDLE.
- Done  out  1  high for exactly one cycle when the product is valid.
- Produto  out  2N  unsigned product.

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high.
- Reset (Rst=1 at a rising edge):
  - state=IDLE, ACC=0, MCAND=0, counter=0.
  - Idle=1, Done=0, Produto=0.
  - Rst has priority over everything, including mid-operation; a partial result is discarded.
- Registers:
  - ACC[2N-1:0] holds the partial product (upper half) and the remaining multiplier bits (lower half).
  - MCAND[N-1:0] holds the multiplicand; cnt holds the step count.
- IDLE:
  - Idle=1.
  - If St=1: ACC<={0,Multiplicador}, MCAND<=Multiplicando, cnt<=0, go to CALC.
  - Otherwise hold all registers.
- CALC:
  - Each cycle: sum[N:0] = ACC[2N-1:N] + (ACC[0] ? MCAND : 0).
  - ACC <= {sum[N:0], ACC[N-1:1]}, cnt<=cnt+1.
  - After the N-th step (cnt==N-1) go to DONE.
- DONE:
  - Done=1 for one cycle; ACC holds; go to IDLE unconditionally.
- Outputs are Moore outputs: Idle=(state==IDLE), Done=(state==DONE). They are never high together.
- Latency: St sampled high at edge k → Done high during the cycle after edge k+N. For N=4, Done is high between edges k+4 and k+5.
- Result validity: Produto=ACC is valid from the Done cycle onward and is held through IDLE until the next start.
- St in CALC or DONE is ignored; there is no queuing.
- St held high continuously starts a new operation on the first IDLE cycle after DONE.
- Operand inputs may change any time after the start edge without affecting the result.
- Arithmetic is unsigned. The carry out of the adder is kept in ACC, so no overflow is possible. Maximum product for N=4: 15×15=225.
- Zero operands still take the full N steps and yield 0.

Optional Feature:
- Macro: MULT_RESULT_REG_EN.
- Defined:
  - A separate 2N-bit result register is loaded with the final sum/shift value on the CALC→DONE transition.
  - Produto drives from this register, so the previous product stays stable during a new computation.
  - The register is cleared to 0 by reset.
- Undefined:
  - Produto mirrors ACC directly, so partial values are visible during CALC.
  - Produto is valid only in DONE and in the IDLE cycles that follow it.
- Done timing and latency are identical in both builds.

Decomposition:
- Package multiplicador_pkg:
  - state typedef enum {IDLE, CALC, DONE};
  - default width constant N_DEF=4;
  - helper constant for the counter width.
- One natural sub-module, multiplicador_datapath: holds ACC, MCAND, the adder and the shift; driven by load/step strobes.
- The top level holds the FSM, cnt and the output decode.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles → Idle=1, Done=0, Produto=0; St=0 keeps the FSM in IDLE.
- Basic product: Multiplicador=4'b1011, Multiplicando=4'b1101, St=1 for one cycle → Done pulses once 4 cycles after the start edge; Produto=8'h8F (143); Idle returns to 1.
- Max operands: Multiplicador=4'b1111, Multiplicando=4'b1111 → Produto=8'hE1 (225), which checks the adder carry path.
- Zero and identity: 0×13 → 0; 1×15 → 8'h0F; Done latency is unchanged.
- Operands and St mid-operation: change operands and pulse St during CALC → result is unaffected (143) and no extra operation starts. Holding St high gives back-to-back operations with Idle high for one cycle between them.
- Reset mid-operation: assert Rst during CALC → next cycle Idle=1, Done=0, Produto=0. A following start yields the correct product.
